// File: rtl/td4_uart_pkg.sv
// Shared constants, state encodings and helpers for the TD4 UART loader.
package td4_uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_I  = 8'h49;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_X  = 8'h58;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [3:0] {
    P_IDLE,
    W_ADDR,
    W_DHI,
    W_DLO,
    W_END,
    I_VAL,
    I_END,
    R_END,
    X_END
  } parse_state_t;

  // ASCII hex digit to {ok, nibble}; ok=0 for any non-hex character.
  function automatic logic [4:0] hex_to_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, 4'(c - 8'h30)};
    if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
    if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
    return 5'b0_0000;
  endfunction

  // Fold lower-case letters onto upper case; other bytes pass unchanged.
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) return 8'(c - 8'h20);
    return c;
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: 2-flop synchronizer, bit timer and receive FSM.
// Ports: mclock, reset_n (async active-low), rx (async serial in);
//        rx_byte / rx_byte_valid (1-cycle pulse), frame_err (1-cycle pulse).
module uart_rx_core
  import td4_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       mclock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

  logic          rx_meta, rx_s;
  rx_state_t     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic [7:0]    rx_byte_d;
  logic          rx_byte_valid_d, frame_err_d;
  logic          cnt_zero;

  // Synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge mclock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State and datapath registers.
  always_ff @(posedge mclock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RX_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      bit_idx       <= bit_idx_d;
      shreg         <= shreg_d;
      rx_byte       <= rx_byte_d;
      rx_byte_valid <= rx_byte_valid_d;
      frame_err     <= frame_err_d;
    end
  end

  assign cnt_zero = (cnt == '0);

  // Next-state: counter runs down to 0, where the line is sampled.
  always_comb begin
    state_d         = state;
    cnt_d           = cnt;
    bit_idx_d       = bit_idx;
    shreg_d         = shreg;
    rx_byte_d       = rx_byte;
    rx_byte_valid_d = 1'b0;
    frame_err_d     = 1'b0;

    case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (cnt_zero) begin
          if (!rx_s) begin
            state_d   = RX_DATA;
            cnt_d     = FULL_LOAD;
            bit_idx_d = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_zero) begin
          shreg_d   = {rx_s, shreg[7:1]};
          cnt_d     = FULL_LOAD;
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_zero) begin
          if (rx_s) begin
            rx_byte_d       = shreg;
            rx_byte_valid_d = 1'b1;
            state_d         = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      RX_BREAK: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/td4_uart_loader.sv
// Serial command loader for the TD4 core: receives bytes and parses
// W<a><dh><dl>, I<v>, X, R commands terminated by CR or LF.
// Ports: mclock, reset_n, rx in; rx_byte/rx_byte_valid/frame_err from the
//        receiver; cmd_err, prog_we/prog_addr/prog_data, in_val/in_valid,
//        cpu_rst_req out. All outputs registered.
module td4_uart_loader
  import td4_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       mclock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic       cmd_err,
  output logic       prog_we,
  output logic [3:0] prog_addr,
  output logic [7:0] prog_data,
  output logic [3:0] in_val,
  output logic       in_valid,
  output logic       cpu_rst_req
);

  uart_rx_core #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .mclock        (mclock),
    .reset_n       (reset_n),
    .rx            (rx),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .frame_err     (frame_err)
  );

  parse_state_t p_state, p_state_d;
  logic [3:0]   wr_addr, wr_addr_d;
  logic [7:0]   wr_data, wr_data_d;
  logic [3:0]   in_nib, in_nib_d;
  logic         cmd_err_d, prog_we_d, cpu_rst_req_d, in_valid_d;
  logic [3:0]   prog_addr_d, in_val_d;
  logic [7:0]   prog_data_d;

  logic [4:0]   hex;
  logic [7:0]   uc;
  logic         term;

  assign hex  = hex_to_nib(rx_byte);
  assign uc   = to_upper(rx_byte);
  assign term = is_term(rx_byte);

  // Parser state, latched fields and committed outputs.
  always_ff @(posedge mclock or negedge reset_n) begin
    if (!reset_n) begin
      p_state     <= P_IDLE;
      wr_addr     <= '0;
      wr_data     <= '0;
      in_nib      <= '0;
      cmd_err     <= 1'b0;
      prog_we     <= 1'b0;
      prog_addr   <= '0;
      prog_data   <= '0;
      in_val      <= '0;
      in_valid    <= 1'b0;
      cpu_rst_req <= 1'b0;
    end else begin
      p_state     <= p_state_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      in_nib      <= in_nib_d;
      cmd_err     <= cmd_err_d;
      prog_we     <= prog_we_d;
      prog_addr   <= prog_addr_d;
      prog_data   <= prog_data_d;
      in_val      <= in_val_d;
      in_valid    <= in_valid_d;
      cpu_rst_req <= cpu_rst_req_d;
    end
  end

  // One received byte per cycle; a framing error silently drops the command.
  always_comb begin
    p_state_d     = p_state;
    wr_addr_d     = wr_addr;
    wr_data_d     = wr_data;
    in_nib_d      = in_nib;
    cmd_err_d     = 1'b0;
    prog_we_d     = 1'b0;
    prog_addr_d   = prog_addr;
    prog_data_d   = prog_data;
    in_val_d      = in_val;
    in_valid_d    = in_valid;
    cpu_rst_req_d = 1'b0;

    if (frame_err) begin
      p_state_d = P_IDLE;
    end else if (rx_byte_valid) begin
      // Default for every non-accepting path; accepted bytes override.
      p_state_d = P_IDLE;
      case (p_state)
        P_IDLE: begin
          if      (uc == ASCII_W) p_state_d = W_ADDR;
          else if (uc == ASCII_I) p_state_d = I_VAL;
          else if (uc == ASCII_R) p_state_d = R_END;
          else if (uc == ASCII_X) p_state_d = X_END;
          else if (!term)         cmd_err_d = 1'b1;
        end
        W_ADDR: begin
          if (hex[4]) begin
            wr_addr_d = hex[3:0];
            p_state_d = W_DHI;
          end else cmd_err_d = 1'b1;
        end
        W_DHI: begin
          if (hex[4]) begin
            wr_data_d[7:4] = hex[3:0];
            p_state_d      = W_DLO;
          end else cmd_err_d = 1'b1;
        end
        W_DLO: begin
          if (hex[4]) begin
            wr_data_d[3:0] = hex[3:0];
            p_state_d      = W_END;
          end else cmd_err_d = 1'b1;
        end
        I_VAL: begin
          if (hex[4]) begin
            in_nib_d  = hex[3:0];
            p_state_d = I_END;
          end else cmd_err_d = 1'b1;
        end
        W_END: begin
          if (term) begin
            prog_we_d   = 1'b1;
            prog_addr_d = wr_addr;
            prog_data_d = wr_data;
          end else cmd_err_d = 1'b1;
        end
        I_END: begin
          if (term) begin
            in_val_d   = in_nib;
            in_valid_d = 1'b1;
          end else cmd_err_d = 1'b1;
        end
        X_END: begin
          if (term) in_valid_d = 1'b0;
          else      cmd_err_d  = 1'b1;
        end
        R_END: begin
          if (term) cpu_rst_req_d = 1'b1;
          else      cmd_err_d     = 1'b1;
        end
        default: p_state_d = P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_uart_loader.sv
// Directed bench: instance a runs at 50 MHz / 115200 (DIV=434) for timing,
// instance b at DIV=16 for command parsing and error recovery.
module tb_td4_uart_loader;

  localparam int unsigned A_DIV  = 434;
  localparam int unsigned B_CLK  = 1_600_000;
  localparam int unsigned B_BAUD = 100_000;
  localparam int unsigned B_DIV  = 16;

  logic mclock  = 1'b0;
  logic reset_n = 1'b0;
  logic rx_a    = 1'b1;
  logic rx_b    = 1'b1;

  logic [7:0] rx_byte_a, prog_data_a;
  logic       valid_a, ferr_a, cmd_err_a, we_a, in_valid_a, rst_a;
  logic [3:0] prog_addr_a, in_val_a;

  logic [7:0] rx_byte_b, prog_data_b;
  logic       valid_b, ferr_b, cmd_err_b, we_b, in_valid_b, rst_b;
  logic [3:0] prog_addr_b, in_val_b;

  td4_uart_loader u_dut_a (
    .mclock (mclock), .reset_n (reset_n), .rx (rx_a),
    .rx_byte (rx_byte_a), .rx_byte_valid (valid_a), .frame_err (ferr_a),
    .cmd_err (cmd_err_a), .prog_we (we_a), .prog_addr (prog_addr_a),
    .prog_data (prog_data_a), .in_val (in_val_a), .in_valid (in_valid_a),
    .cpu_rst_req (rst_a)
  );

  td4_uart_loader #(.CLK_HZ (B_CLK), .BAUD (B_BAUD)) u_dut_b (
    .mclock (mclock), .reset_n (reset_n), .rx (rx_b),
    .rx_byte (rx_byte_b), .rx_byte_valid (valid_b), .frame_err (ferr_b),
    .cmd_err (cmd_err_b), .prog_we (we_b), .prog_addr (prog_addr_b),
    .prog_data (prog_data_b), .in_val (in_val_b), .in_valid (in_valid_b),
    .cpu_rst_req (rst_b)
  );

  always #10 mclock = ~mclock;

  int cyc = 0;
  always @(posedge mclock) cyc = cyc + 1;

  int na_valid = 0, na_ferr = 0, t_start_a = 0, t_valid_a = -1;
  int nb_valid = 0, nb_ferr = 0, nb_cmd = 0, nb_we = 0, nb_rst = 0;

  // Pulse counters, sampled mid-cycle.
  always @(negedge mclock) begin
    if (valid_a) begin
      na_valid = na_valid + 1;
      if (t_valid_a < 0) t_valid_a = cyc;
    end
    if (ferr_a)    na_ferr  = na_ferr + 1;
    if (valid_b)   nb_valid = nb_valid + 1;
    if (ferr_b)    nb_ferr  = nb_ferr + 1;
    if (cmd_err_b) nb_cmd   = nb_cmd + 1;
    if (we_b)      nb_we    = nb_we + 1;
    if (rst_b)     nb_rst   = nb_rst + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge mclock);
  endtask

  task automatic send_bit(input bit sel, input logic v, input int n);
    if (sel) rx_b = v;
    else     rx_a = v;
    idle(n);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop);
    int n;
    n = sel ? int'(B_DIV) : int'(A_DIV);
    if (!sel) t_start_a = cyc;
    send_bit(sel, 1'b0, n);
    for (int i = 0; i < 8; i++) send_bit(sel, b[i], n);
    send_bit(sel, stop, n);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(1'b1, s[i], 1'b1);
    idle(4);
  endtask

  int nv;
  logic [7:0] pb;

  initial begin
    idle(5);
    chk("rst_rx_byte_a",  32'(rx_byte_a), 32'h0);
    chk("rst_rx_byte_b",  32'(rx_byte_b), 32'h0);
    chk("rst_prog_addr",  32'(prog_addr_b), 32'h0);
    chk("rst_prog_data",  32'(prog_data_b), 32'h0);
    chk("rst_in_val",     32'(in_val_b), 32'h0);
    chk("rst_in_valid",   32'(in_valid_b), 32'h0);
    reset_n = 1'b1;
    idle(5);

    // 0x55 at full rate: count, value, latency 2 + 9.5*434 + 1 = 4126.
    send_byte(1'b0, 8'h55, 1'b1);
    idle(10);
    chk("a55_valid_cnt", 32'(na_valid), 32'd1);
    chk("a55_byte",      32'(rx_byte_a), 32'h55);
    chk("a55_ferr_cnt",  32'(na_ferr), 32'd0);
    chk("a55_latency",   32'(t_valid_a - t_start_a), 32'd4126);

    // Low glitch of DIV/4 is rejected in START.
    rx_a = 1'b0;
    idle(A_DIV / 4);
    rx_a = 1'b1;
    idle(2 * A_DIV);
    chk("glitch_valid_cnt", 32'(na_valid), 32'd1);
    chk("glitch_ferr_cnt",  32'(na_ferr), 32'd0);

    send_str("W3B7\015");
    chk("w3b7_we_cnt", 32'(nb_we), 32'd1);
    chk("w3b7_addr",   32'(prog_addr_b), 32'h3);
    chk("w3b7_data",   32'(prog_data_b), 32'hB7);
    chk("w3b7_cmderr", 32'(nb_cmd), 32'd0);
    send_str("\012");
    chk("lf_we_cnt",     32'(nb_we), 32'd1);
    chk("lf_cmderr",     32'(nb_cmd), 32'd0);

    send_str("I9\012");
    chk("i9_in_val",   32'(in_val_b), 32'h9);
    chk("i9_in_valid", 32'(in_valid_b), 32'h1);
    send_str("x\015");
    chk("x_in_valid",  32'(in_valid_b), 32'h0);
    chk("x_in_val",    32'(in_val_b), 32'h9);
    send_str("R\015");
    chk("r_rst_cnt",   32'(nb_rst), 32'd1);

    send_str("WG");
    chk("wg_cmderr",   32'(nb_cmd), 32'd1);
    chk("wg_we_cnt",   32'(nb_we), 32'd1);
    send_str("w0fF\015");
    chk("w0ff_we_cnt", 32'(nb_we), 32'd2);
    chk("w0ff_addr",   32'(prog_addr_b), 32'h0);
    chk("w0ff_data",   32'(prog_data_b), 32'hFF);
    chk("w0ff_cmderr", 32'(nb_cmd), 32'd1);

    // Framing error mid-command, line held low longer than a frame.
    nv = nb_valid;
    send_str("W5");
    send_byte(1'b1, 8'h00, 1'b0);
    idle(12 * B_DIV);
    chk("brk_ferr_cnt",  32'(nb_ferr), 32'd1);
    chk("brk_valid_cnt", 32'(nb_valid), 32'(nv + 2));
    chk("brk_cmderr",    32'(nb_cmd), 32'd1);
    rx_b = 1'b1;
    idle(2 * B_DIV);
    send_str("\015");
    chk("brk_abort_we",  32'(nb_we), 32'd2);
    chk("brk_abort_err", 32'(nb_cmd), 32'd1);
    send_byte(1'b1, 8'hA5, 1'b1);
    idle(4);
    chk("a5_byte",      32'(rx_byte_b), 32'hA5);
    chk("a5_valid_cnt", 32'(nb_valid), 32'(nv + 4));
    chk("a5_ferr_cnt",  32'(nb_ferr), 32'd1);
    chk("a5_cmderr",    32'(nb_cmd), 32'd2);

    // Reset during bit 4 of 0x3C.
    send_str("I6\015");
    chk("i6_in_valid", 32'(in_valid_b), 32'h1);
    chk("i6_in_val",   32'(in_val_b), 32'h6);
    nv = nb_valid;
    pb = 8'h3C;
    send_bit(1'b1, 1'b0, B_DIV);
    for (int i = 0; i < 4; i++) send_bit(1'b1, pb[i], B_DIV);
    rx_b = pb[4];
    idle(B_DIV / 2);
    reset_n = 1'b0;
    idle(3);
    chk("mid_rst_rx_byte",   32'(rx_byte_b), 32'h0);
    chk("mid_rst_in_valid",  32'(in_valid_b), 32'h0);
    chk("mid_rst_in_val",    32'(in_val_b), 32'h0);
    chk("mid_rst_prog_data", 32'(prog_data_b), 32'h0);
    rx_b = 1'b1;
    reset_n = 1'b1;
    idle(3 * B_DIV);
    chk("mid_rst_no_valid", 32'(nb_valid), 32'(nv));
    send_byte(1'b1, 8'h3C, 1'b1);
    idle(4);
    chk("3c_byte",      32'(rx_byte_b), 32'h3C);
    chk("3c_valid_cnt", 32'(nb_valid), 32'(nv + 1));
    chk("3c_we_cnt",    32'(nb_we), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
